// File: rtl/mux_4_pkg.sv
// mux_4_pkg: shared constants and the 4-state select resolution used by mux_4.
//
// Contents:
//   N_IN, SEL_W    - number of data inputs and width of the select code
//   bit_unknown()  - true when a single bit is X or Z
//   resolve_sel()  - 4-state mux resolution
//
// resolve_sel() finds every input index that agrees with the known select bits.
// It returns their common value when all of those inputs are known and equal,
// and X otherwise.
package mux_4_pkg;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned SEL_W = 2;

  // Synthesis folds this to 0, because real hardware never holds X or Z.
  function automatic logic bit_unknown(input logic b);
    return (b !== 1'b0) && (b !== 1'b1);
  endfunction

  function automatic logic resolve_sel(input logic [N_IN-1:0]  in_bits,
                                       input logic [SEL_W-1:0] sel_bits);
    logic found;
    logic conflict;
    logic val;
    logic match;
    found    = 1'b0;
    conflict = 1'b0;
    val      = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) begin
      // An X/Z select bit matches either value of that index bit.
      match = 1'b1;
      for (int b = 0; b < int'(SEL_W); b++) begin
        if (!bit_unknown(sel_bits[b]) && (sel_bits[b] != i[b])) begin
          match = 1'b0;
        end
      end
      if (match) begin
        if (bit_unknown(in_bits[i])) begin
          conflict = 1'b1;
        end else if (!found) begin
          found = 1'b1;
          val   = in_bits[i];
        end else if (in_bits[i] != val) begin
          conflict = 1'b1;
        end
      end
    end
    return conflict ? 1'bx : val;
  endfunction

endpackage

// File: rtl/mux_4_resolve.sv
// mux_4_resolve: purely combinational 4:1 mux with 4-state select resolution.
//
// Ports:
//   in  [3:0] - data inputs; in[0] for sel=00 through in[3] for sel=11
//   sel [1:0] - select code; X/Z bits widen the set of candidate inputs
//   out       - the selected value, or X when the candidates are unknown or disagree
module mux_4_resolve
  import mux_4_pkg::*;
(
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  always_comb begin
    out = resolve_sel(in, sel);
  end

endmodule

// File: rtl/mux_4.sv
// mux_4: 4:1 mux with a combinational output and an optional registered copy.
//
// Ports:
//   clk       - clock; out_q samples out on the rising edge
//   rst       - asynchronous active-high reset; forces out_q to RESET_VAL
//   in  [3:0] - data inputs
//   sel [1:0] - select code
//   out       - combinational mux result; reset does not affect it
//   out_q     - registered copy of out (one cycle of latency), or out itself
//
// Build option:
//   MUX_4_REG_OUT_EN defined   -> out_q is a flop with async reset to RESET_VAL
//   MUX_4_REG_OUT_EN undefined -> out_q is wired to out; clk, rst, RESET_VAL unused
module mux_4
  import mux_4_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             out_q
);

  mux_4_resolve u_resolve (
    .in  (in),
    .sel (sel),
    .out (out)
  );

`ifdef MUX_4_REG_OUT_EN
  logic out_d;

  always_comb begin
    out_d = out;
  end

  // Async reset: it takes effect at once and also wins over a clock edge in the same timestep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= RESET_VAL;
    end else begin
      out_q <= out_d;
    end
  end
`else
  logic unused_reg_inputs;

  assign unused_reg_inputs = ^{clk, rst, RESET_VAL};
  assign out_q             = out;
`endif

endmodule

// File: tb/tb_mux_4.sv
// tb_mux_4: directed self-checking bench for mux_4 with hand-computed expectations.
// It covers both builds; the MUX_4_REG_OUT_EN sections follow the design's build option.
// X-expected vectors are checked only on a 4-state simulator.
module tb_mux_4;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [3:0] in_r;
  logic [1:0] sel_r;
  logic       out;
  logic       out_q;

  int total;
  int bad;
  logic probe;
  bit   four_state;

  mux_4 #(
    .RESET_VAL (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_r),
    .sel   (sel_r),
    .out   (out),
    .out_q (out_q)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  localparam int NVec = 12;
  logic [3:0] vin  [NVec];
  logic [1:0] vsel [NVec];
  logic       vexp [NVec];
  bit         vx   [NVec];

  initial begin
    vin[0]  = 4'b0001; vsel[0]  = 2'b00; vexp[0]  = 1'b1; vx[0]  = 0;
    vin[1]  = 4'b0100; vsel[1]  = 2'b01; vexp[1]  = 1'b0; vx[1]  = 0;
    vin[2]  = 4'b1101; vsel[2]  = 2'b10; vexp[2]  = 1'b1; vx[2]  = 0;
    vin[3]  = 4'b1001; vsel[3]  = 2'b10; vexp[3]  = 1'b0; vx[3]  = 0;
    vin[4]  = 4'b0010; vsel[4]  = 2'b01; vexp[4]  = 1'b1; vx[4]  = 0;
    vin[5]  = 4'bxxx0; vsel[5]  = 2'b00; vexp[5]  = 1'b0; vx[5]  = 0;
    vin[6]  = 4'b1x10; vsel[6]  = 2'b11; vexp[6]  = 1'b1; vx[6]  = 0;
    vin[7]  = 4'bx000; vsel[7]  = 2'b11; vexp[7]  = 1'bx; vx[7]  = 1;
    vin[8]  = 4'b1111; vsel[8]  = 2'bxx; vexp[8]  = 1'b1; vx[8]  = 0;
    vin[9]  = 4'b0111; vsel[9]  = 2'b1x; vexp[9]  = 1'bx; vx[9]  = 1;
    vin[10] = 4'b1010; vsel[10] = 2'bx1; vexp[10] = 1'b1; vx[10] = 0;
    vin[11] = 4'b0010; vsel[11] = 2'bx1; vexp[11] = 1'bx; vx[11] = 1;
  end

  initial begin
    total  = 0;
    bad    = 0;
    probe  = 1'bx;
    four_state = (probe !== 1'b0) && (probe !== 1'b1);
    clk    = 1'b0;
    clk_en = 1'b1;
    rst    = 1'b1;
    in_r   = 4'b0001;
    sel_r  = 2'b00;
    #2;
    // Reset does not touch out.
    check_bit("reset_out", out, 1'b1);
`ifdef MUX_4_REG_OUT_EN
    check_bit("reset_out_q", out_q, 1'b0);
    @(posedge clk); #1;
    check_bit("reset_hold_out_q", out_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("release_no_edge_out_q", out_q, 1'b0);
    @(posedge clk); #1;
    check_bit("release_first_edge_out_q", out_q, 1'b1);
`else
    check_bit("reset_out_q", out_q, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("release_out_q", out_q, 1'b1);
`endif

    for (int i = 0; i < NVec; i++) begin
      if (!vx[i] || four_state) begin
        @(negedge clk);
        in_r  = vin[i];
        sel_r = vsel[i];
        #1;
        check_bit($sformatf("vec%0d_out", i), out, vexp[i]);
`ifdef MUX_4_REG_OUT_EN
        @(posedge clk); #1;
`endif
        check_bit($sformatf("vec%0d_out_q", i), out_q, vexp[i]);
      end
    end

`ifdef MUX_4_REG_OUT_EN
    // One cycle of latency on a falling out.
    @(negedge clk);
    in_r  = 4'b0001;
    sel_r = 2'b00;
    @(posedge clk); #1;
    check_bit("lat_setup_out_q", out_q, 1'b1);
    @(negedge clk);
    in_r = 4'b0000;
    #1;
    check_bit("lat_out_now", out, 1'b0);
    check_bit("lat_out_q_hold", out_q, 1'b1);
    @(posedge clk); #1;
    check_bit("lat_out_q_edge", out_q, 1'b0);

    // Async reset pulse between edges.
    @(negedge clk);
    in_r = 4'b0001;
    @(posedge clk); #1;
    check_bit("pulse_setup_out_q", out_q, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("pulse_out_q", out_q, 1'b0);
    check_bit("pulse_out", out, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_bit("pulse_release_out_q", out_q, 1'b0);
    @(posedge clk); #1;
    check_bit("pulse_recover_out_q", out_q, 1'b1);

    // Reset raised in the same timestep as a clock edge wins.
    @(posedge clk);
    rst = 1'b1;
    #1;
    check_bit("same_step_out_q", out_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
`else
    // With the clock stopped, out_q follows out immediately, and reset has no effect.
    clk_en = 1'b0;
    sel_r  = 2'b10;
    in_r   = 4'b0100;
    #1;
    check_bit("stopped_a_out", out, 1'b1);
    check_bit("stopped_a_out_q", out_q, 1'b1);
    in_r = 4'b0000;
    #1;
    check_bit("stopped_b_out", out, 1'b0);
    check_bit("stopped_b_out_q", out_q, 1'b0);
    rst  = 1'b1;
    in_r = 4'b0100;
    #1;
    check_bit("stopped_rst_out_q", out_q, 1'b1);
    sel_r = 2'b11;
    #1;
    check_bit("stopped_sel_out_q", out_q, 1'b0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
